// File: rtl/vec_issue_ctrl.sv
// Vector issue sequencer between ID and the CGRA accelerator.
// Captures vector ops, runs the start/ack/done handshake, writes back.
module vec_issue_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            inst_valid_i,
  input  logic [6:0]      op_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            accept_o,
  output logic            stall_o,
  output logic            cgra_start_o,
  output logic [9:0]      cgra_cfg_o,
  output logic [XLEN-1:0] cgra_op_a_o,
  output logic [XLEN-1:0] cgra_op_b_o,
  input  logic            cgra_ack_i,
  input  logic            cgra_done_i,
  input  logic [XLEN-1:0] cgra_result_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            timeout_o
);

  localparam int         WDW    = $clog2(TIMEOUT);
  localparam logic [6:0] VEC_OP = 7'b1010111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BUSY,
    WB
  } state_t;

  state_t         state;
  logic [WDW-1:0] wd_q;
  logic           capture;
  logic           wd_hit;

  assign capture = (state == IDLE) && inst_valid_i
                && (op_i == VEC_OP) && !flush_i;
  assign wd_hit  = (wd_q == WDW'(TIMEOUT - 1));

  assign accept_o = capture;
  assign stall_o  = (state == REQ) || (state == BUSY);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      wd_q         <= '0;
      cgra_start_o <= 1'b0;
      cgra_cfg_o   <= '0;
      cgra_op_a_o  <= '0;
      cgra_op_b_o  <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      timeout_o    <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      timeout_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (capture) begin
            state        <= REQ;
            wd_q         <= '0;
            cgra_start_o <= 1'b1;
            cgra_cfg_o   <= {funct7_i, funct3_i};
            cgra_op_a_o  <= rs1_data_i;
            cgra_op_b_o  <= rs2_data_i;
            wb_rd_o      <= rd_i;
          end
        end
        REQ: begin
          wd_q <= wd_q + WDW'(1);
          if (cgra_ack_i && cgra_done_i) begin
            state        <= WB;
            cgra_start_o <= 1'b0;
            wb_data_o    <= cgra_result_i;
            wb_valid_o   <= |wb_rd_o;
          end else if (cgra_ack_i) begin
            state        <= BUSY;
            cgra_start_o <= 1'b0;
          end else if (wd_hit) begin
            state        <= IDLE;
            cgra_start_o <= 1'b0;
            timeout_o    <= 1'b1;
          end
        end
        BUSY: begin
          wd_q <= wd_q + WDW'(1);
          if (cgra_done_i) begin
            state      <= WB;
            wb_data_o  <= cgra_result_i;
            wb_valid_o <= |wb_rd_o;
          end else if (wd_hit) begin
            state     <= IDLE;
            timeout_o <= 1'b1;
          end
        end
        WB: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed bench for vec_issue_ctrl with a transaction-level
// reference model compared on every falling edge.
module tb_vec_issue_ctrl;

  localparam int XLEN = 32;
  localparam int TMO  = 8;
  localparam logic [6:0] VEC = 7'b1010111;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            inst_valid = 1'b0;
  logic [6:0]      op = '0;
  logic [2:0]      funct3 = '0;
  logic [6:0]      funct7 = '0;
  logic [4:0]      rd = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            flush = 1'b0;
  logic            ack = 1'b0;
  logic            done = 1'b0;
  logic [XLEN-1:0] result = '0;

  logic            accept_o, stall_o, cgra_start_o;
  logic [9:0]      cgra_cfg_o;
  logic [XLEN-1:0] cgra_op_a_o, cgra_op_b_o;
  logic            wb_valid_o, timeout_o;
  logic [4:0]      wb_rd_o;
  logic [XLEN-1:0] wb_data_o;

  vec_issue_ctrl #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .inst_valid_i  (inst_valid),
    .op_i          (op),
    .funct3_i      (funct3),
    .funct7_i      (funct7),
    .rd_i          (rd),
    .rs1_data_i    (rs1),
    .rs2_data_i    (rs2),
    .flush_i       (flush),
    .accept_o      (accept_o),
    .stall_o       (stall_o),
    .cgra_start_o  (cgra_start_o),
    .cgra_cfg_o    (cgra_cfg_o),
    .cgra_op_a_o   (cgra_op_a_o),
    .cgra_op_b_o   (cgra_op_b_o),
    .cgra_ack_i    (ack),
    .cgra_done_i   (done),
    .cgra_result_i (result),
    .wb_valid_o    (wb_valid_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding op, its age and ack status.
  logic            m_busy = 0, m_acked = 0, m_wb = 0, m_to = 0;
  int              m_age = 0;
  logic [9:0]      m_cfg = '0;
  logic [XLEN-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [4:0]      m_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_acked <= 0; m_wb <= 0; m_to <= 0; m_age <= 0;
      m_cfg <= '0; m_a <= '0; m_b <= '0; m_res <= '0; m_rd <= '0;
    end else begin
      m_wb <= 0;
      m_to <= 0;
      if (m_busy) begin
        if (!m_acked && ack && done) begin
          m_busy <= 0; m_wb <= 1; m_res <= result;
        end else if (!m_acked && ack) begin
          m_acked <= 1; m_age <= m_age + 1;
        end else if (m_acked && done) begin
          m_busy <= 0; m_wb <= 1; m_res <= result;
        end else if (m_age == TMO - 1) begin
          m_busy <= 0; m_to <= 1;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (!m_wb && inst_valid && op == VEC && !flush) begin
        m_busy <= 1; m_acked <= 0; m_age <= 0;
        m_cfg <= {funct7, funct3}; m_a <= rs1; m_b <= rs2; m_rd <= rd;
      end
    end
  end

  int ncyc = 0, acc_n = 0, wb_n = 0, wb_cnt = 0, acc_cnt = 0;

  always @(negedge clk) begin
    chk("accept", accept_o,
        !m_busy && !m_wb && inst_valid && op == VEC && !flush && rst_n);
    chk("stall", stall_o, m_busy);
    chk("start", cgra_start_o, m_busy && !m_acked);
    chk("cfg", cgra_cfg_o, m_cfg);
    chk("op_a", cgra_op_a_o, m_a);
    chk("op_b", cgra_op_b_o, m_b);
    chk("wb_valid", wb_valid_o, m_wb && (m_rd != 0));
    chk("timeout", timeout_o, m_to);
    if (m_wb) begin
      chk("wb_rd", wb_rd_o, m_rd);
      chk("wb_data", wb_data_o, m_res);
    end
    ncyc <= ncyc + 1;
    if (accept_o) begin
      acc_n   <= ncyc;
      acc_cnt <= acc_cnt + 1;
    end
    if (wb_valid_o) begin
      wb_n   <= ncyc;
      wb_cnt <= wb_cnt + 1;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [6:0] f7, logic [2:0] f3, logic [4:0] d,
                       logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    inst_valid = 1; op = VEC; funct7 = f7; funct3 = f3;
    rd = d; rs1 = a; rs2 = b;
    tick(1);
    inst_valid = 0; op = '0;
  endtask

  int k;
  int snap;
  logic hit;

  initial begin
    // reset then idle with a non-vector opcode
    tick(3);
    chk("rst_start", cgra_start_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_cfg", cgra_cfg_o, 0);
    rst_n = 1;
    inst_valid = 1; op = 7'b0110011;
    tick(10);
    inst_valid = 0; op = '0;
    chk("idle_accepts", acc_cnt, 0);

    // basic issue: ack after one cycle, done four cycles after capture
    issue(7'h01, 3'b000, 5'd3, 5, 7);
    chk("basic_cfg", cgra_cfg_o, 10'h008);
    chk("basic_start", cgra_start_o, 1);
    chk("basic_stall", stall_o, 1);
    ack = 1; tick(1); ack = 0;
    chk("basic_busy_stall", stall_o, 1);
    tick(2);
    done = 1; result = 12; tick(1); done = 0;
    chk("basic_wbv", wb_valid_o, 1);
    chk("basic_rd", wb_rd_o, 3);
    chk("basic_data", wb_data_o, 12);
    chk("basic_stall_drop", stall_o, 0);
    tick(1);
    chk("basic_wbv_end", wb_valid_o, 0);

    // combined ack+done
    issue(7'h02, 3'b011, 5'd31, 32'h1111, 32'h2222);
    ack = 1; done = 1; result = 32'hDEADBEEF;
    tick(1); ack = 0; done = 0;
    chk("comb_wbv", wb_valid_o, 1);
    chk("comb_data", wb_data_o, 32'hDEADBEEF);
    chk("comb_rd", wb_rd_o, 31);
    tick(1);
    chk("comb_latency", wb_n - acc_n, 2);

    // flushed vector op is not accepted
    inst_valid = 1; op = VEC; flush = 1; rd = 5'd6;
    #1 chk("flush_accept", accept_o, 0);
    tick(1);
    flush = 0; inst_valid = 0; op = '0;
    // x0 destination: handshake completes, no write strobe
    snap = wb_cnt;
    issue(7'h03, 3'b001, 5'd0, 1, 2);
    ack = 1; tick(1); ack = 0;
    done = 1; result = 32'h77; tick(1); done = 0;
    chk("x0_wbv", wb_valid_o, 0);
    chk("x0_stall", stall_o, 0);
    tick(2);
    chk("x0_wbcnt", wb_cnt, snap);

    // stray ack in IDLE is ignored
    ack = 1; tick(1); ack = 0;
    chk("idle_ack_stall", stall_o, 0);

    // watchdog with a stray done in REQ
    snap = wb_cnt;
    issue(7'h04, 3'b010, 5'd8, 3, 4);
    k = 0; hit = 0;
    while (k < 20 && !hit) begin
      done = (k == 2);
      tick(1);
      k++;
      hit = timeout_o;
    end
    done = 0;
    chk("wd_cycles", k, TMO);
    chk("wd_start", cgra_start_o, 0);
    chk("wd_stall", stall_o, 0);
    tick(1);
    chk("wd_pulse_end", timeout_o, 0);
    chk("wd_no_wb", wb_cnt, snap);

    // next op issues normally, separate ack then done
    issue(7'h20, 3'b101, 5'd9, 32'hA, 32'hB);
    chk("next_cfg", cgra_cfg_o, 10'h105);
    ack = 1; tick(1); ack = 0;
    done = 1; result = 32'h55; tick(1); done = 0;
    chk("next_wbv", wb_valid_o, 1);
    chk("next_data", wb_data_o, 32'h55);
    tick(1);
    chk("next_latency", wb_n - acc_n, 3);

    // async reset while BUSY
    issue(7'h05, 3'b100, 5'd4, 9, 9);
    ack = 1; tick(1); ack = 0;
    chk("mid_busy", stall_o, 1);
    snap = wb_cnt;
    #2 rst_n = 0;
    #1;
    chk("arst_stall", stall_o, 0);
    chk("arst_start", cgra_start_o, 0);
    chk("arst_cfg", cgra_cfg_o, 0);
    @(posedge clk); #1 rst_n = 1;
    done = 1; result = 32'h99; tick(1); done = 0;
    tick(3);
    chk("arst_no_wb", wb_cnt, snap);
    chk("arst_idle", stall_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
